// File: rtl/f2c_if.sv
// rtl/f2c_if.sv - start/busy/done handshake bundle for the Fahrenheit-to-Celsius converter
interface f2c_if #(
    parameter int F_W = 7,
    parameter int C_W = 5
);
    logic           start;
    logic [F_W-1:0] f;
    logic           busy;
    logic           done;
    logic [C_W-1:0] c;
    logic           err;

    modport master (output start, f, input busy, done, c, err);
    modport slave  (input start, f, output busy, done, c, err);
endinterface

// File: rtl/f_to_c_converter.sv
// rtl/f_to_c_converter.sv - sequential (f-32)*5/9 converter, shift-add x5 and restoring /9
// Optional F2C_ROUND_EN: bias the dividend by +4 so the quotient rounds to nearest.
module f_to_c_converter #(
    parameter int F_W = 7,
    parameter int C_W = 5
) (
    input  logic  clk,
    input  logic  rst,
    f2c_if.slave  bus
);
    localparam int P_W   = F_W + 3;
    localparam int CNT_W = $clog2(P_W);

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    state_t           state;
    logic [F_W-1:0]   f_reg;
    logic [P_W-1:0]   p;
    logic [P_W-1:0]   quo;
    logic [3:0]       rem;
    logic [CNT_W-1:0] cnt;
    logic             under;

    logic [F_W-1:0]   d;
    logic [P_W-1:0]   p_init;
    logic [4:0]       rem_sh;
    logic             ge;
    logic [3:0]       rem_nx;
    logic [P_W-1:0]   quo_nx;
    logic             sat;

    always_comb begin
        d      = f_reg - F_W'(32);
        p_init = ({3'b000, d} << 2) + {3'b000, d};
`ifdef F2C_ROUND_EN
        p_init = p_init + P_W'(4);
`endif
        // remainder stays below 9, so the shifted value fits in 5 bits
        rem_sh = {rem, p[P_W-1]};
        ge     = (rem_sh >= 5'd9);
        rem_nx = ge ? 4'(rem_sh - 5'd9) : rem_sh[3:0];
        quo_nx = {quo[P_W-2:0], ge};
        sat    = |quo_nx[P_W-1:C_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            f_reg    <= '0;
            p        <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            under    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.c    <= '0;
            bus.err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        f_reg    <= bus.f;
                        bus.busy <= 1'b1;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    under <= (f_reg < F_W'(32));
                    p     <= (f_reg < F_W'(32)) ? '0 : p_init;
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= CNT_W'(P_W - 1);
                    state <= DIV;
                end
                DIV: begin
                    p   <= p << 1;
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - 1'b1;
                    // the final quotient bit is folded in via quo_nx on the same edge
                    if (cnt == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        if (under) begin
                            bus.c   <= '0;
                            bus.err <= 1'b1;
                        end else if (sat) begin
                            bus.c   <= '1;
                            bus.err <= 1'b1;
                        end else begin
                            bus.c   <= quo_nx[C_W-1:0];
                            bus.err <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_f_to_c_converter.sv
// tb/tb_f_to_c_converter.sv - scoreboard bench for f_to_c_converter
module tb_f_to_c_converter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int c;
        int e;
        int cyc;
    } exp_t;
    exp_t sb[$];

    f2c_if #(.F_W(7), .C_W(5)) bus ();

    f_to_c_converter #(.F_W(7), .C_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model(input int fv, output int ce, output int ee);
        int q;
        if (fv < 32) begin
            ce = 0;
            ee = 1;
        end else begin
`ifdef F2C_ROUND_EN
            q = ((fv - 32) * 5 + 4) / 9;
`else
            q = ((fv - 32) * 5) / 9;
`endif
            if (q > 31) begin
                ce = 31;
                ee = 1;
            end else begin
                ce = q;
                ee = 0;
            end
        end
    endfunction

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("c", int'(bus.c), e.c);
                chk("err", int'(bus.err), e.e);
                chk("latency", cyc - e.cyc, 11);
            end
        end
    end

    task automatic push_exp(input int ce, input int ee);
        exp_t e;
        e.c = ce;
        e.e = ee;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // issue one conversion from IDLE; use_model=0 means ce/ee are given directly
    task automatic conv(input int fv, input bit use_model, input int ce, input int ee);
        int mc, me;
        @(negedge clk);
        bus.start = 1'b1;
        bus.f = 7'(fv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.f = 7'($urandom);
        if (use_model) begin
            model(fv, mc, me);
            push_exp(mc, me);
        end else begin
            push_exp(ce, ee);
        end
        chk("busy_after_accept", int'(bus.busy), 1);
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.start = 1'b1;
        bus.f = 7'd50;
        repeat (3) @(negedge clk);
        chk("rst_c", int'(bus.c), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(bus.busy), 0);

        conv(50, 1'b0, 10, 0);
`ifdef F2C_ROUND_EN
        conv(87, 1'b0, 31, 0);
`else
        conv(87, 1'b0, 30, 0);
`endif
        conv(100, 1'b0, 31, 1);
        conv(20, 1'b0, 0, 1);
        conv(31, 1'b0, 0, 1);
        conv(127, 1'b0, 31, 1);

        // start held high through a busy f=32 conversion is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.f = 7'd32;
        @(posedge clk);
        #1;
        push_exp(0, 0);
        bus.f = 7'd41;
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) chk("done_timeout_busy", 0, 1);
        @(posedge clk);
        #1;
        chk("idle_after_done", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        push_exp(5, 0);
        bus.start = 1'b0;
        chk("reaccept_busy", int'(bus.busy), 1);
        wait_done();

        // abort mid-DIV
        @(negedge clk);
        bus.start = 1'b1;
        bus.f = 7'd90;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_c", int'(bus.c), 0);
        chk("abort_err", int'(bus.err), 0);
        chk("abort_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        conv(68, 1'b1, 0, 0);

        // round trip: f = 32 + ceil(9c/5) converts back to c in both builds
        for (int ci = 0; ci < 32; ci++)
            conv(32 + (9 * ci + 4) / 5, 1'b0, ci, 0);

        for (int i = 0; i < 40; i++)
            conv(int'($urandom_range(0, 127)), 1'b1, 0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
